// File: rtl/care_input_pkg.sv
// Shared definitions for the care_input front end and the stat block it feeds.
// Action indices double as bit positions on the action bus.
package care_input_pkg;

   localparam int ACT_FEED  = 0;
   localparam int ACT_PLAY  = 1;
   localparam int ACT_HEAL  = 2;
   localparam int ACT_CLEAN = 3;
   localparam int ACT_SLEEP = 4;
   localparam int ACT_CHAT  = 5;

   localparam int NUM_ACTIONS_DEFAULT = 6;

   localparam logic [15:0] LFSR_MASK = 16'hB400;

   typedef enum logic [1:0] {
      BROWSE   = 2'd0,
      FIRE     = 2'd1,
      COOLDOWN = 2'd2
   } state_t;

   // Galois right shift: the feedback taps are applied when the bit shifted out is 1.
   function automatic logic [15:0] lfsrStep(input logic [15:0] value);
      return (value >> 1) ^ (value[0] ? LFSR_MASK : 16'h0000);
   endfunction

endpackage

// File: rtl/care_input_if.sv
// Button inputs and navigation/action outputs of the care_input front end.
// The master side owns the raw buttons; the slave side is the front end itself.
interface care_input_if;

   logic       btn_next;
   logic       btn_select;
   logic [7:0] actions;
   logic [2:0] random;
   logic [2:0] menu_sel;
   logic       busy;

   modport master (
      output btn_next,
      output btn_select,
      input  actions,
      input  random,
      input  menu_sel,
      input  busy
   );

   modport slave (
      input  btn_next,
      input  btn_select,
      output actions,
      output random,
      output menu_sel,
      output busy
   );

endinterface

// File: rtl/care_input_button_debounce.sv
// Two-flop synchroniser, stability counter and registered rising-edge pulse
// for one raw push-button.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 270000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   output logic o_press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic             r_stableDly;
   logic             r_press;
   logic [CNT_W-1:0] r_count;

   // The stable level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_stable    <= 1'b0;
         r_stableDly <= 1'b0;
         r_press     <= 1'b0;
         r_count     <= '0;
      end else begin
         r_sync1     <= i_btn;
         r_sync2     <= r_sync1;
         r_stableDly <= r_stable;
         r_press     <= r_stable & ~r_stableDly;
         if (r_sync2 == r_stable) begin
            r_count <= '0;
         end else if (r_count == CNT_MAX) begin
            r_stable <= ~r_stable;
            r_count  <= '0;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/care_input.sv
// Menu front end: debounced next/select navigation, one-cycle action pulses
// with a select cooldown, and the LFSR that picks which stat decays.
module care_input
   import care_input_pkg::*;
#(
   parameter int          DEBOUNCE_CYCLES = 270000,
   parameter int          COOLDOWN_CYCLES = 13500000,
   parameter int          NUM_ACTIONS     = NUM_ACTIONS_DEFAULT,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic         clk,
   input  logic         reset,
   care_input_if.slave  bus
);

   localparam int COOL_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
   localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN_CYCLES - 1);
   localparam logic [2:0] MENU_LAST = 3'(NUM_ACTIONS - 1);

   logic              w_nextPress;
   logic              w_selPress;
   logic [2:0]        w_menuNext;
   logic [15:0]       w_lfsrNext;

   state_t            r_state;
   logic [2:0]        r_menuSel;
   logic [7:0]        r_actions;
   logic              r_busy;
   logic [COOL_W-1:0] r_cool;
   logic [15:0]       r_lfsr;
   logic [2:0]        r_random;

   button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_nextDebounce (
      .clk     (clk),
      .reset   (reset),
      .i_btn   (bus.btn_next),
      .o_press (w_nextPress)
   );

   button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_selDebounce (
      .clk     (clk),
      .reset   (reset),
      .i_btn   (bus.btn_select),
      .o_press (w_selPress)
   );

   assign w_menuNext = (r_menuSel == MENU_LAST) ? 3'd0 : r_menuSel + 3'd1;

   // Select takes priority over next in BROWSE; in COOLDOWN select presses are simply lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= BROWSE;
         r_menuSel <= 3'd0;
         r_actions <= 8'h00;
         r_busy    <= 1'b0;
         r_cool    <= '0;
      end else begin
         r_actions <= 8'h00;
         unique case (r_state)
            BROWSE: begin
               if (w_selPress) begin
                  r_state   <= FIRE;
                  r_actions <= 8'h01 << r_menuSel;
                  r_busy    <= 1'b1;
               end else if (w_nextPress) begin
                  r_menuSel <= w_menuNext;
               end
            end
            FIRE: begin
               r_state <= COOLDOWN;
               r_cool  <= COOL_LOAD;
               r_busy  <= 1'b1;
            end
            COOLDOWN: begin
               if (w_nextPress) begin
                  r_menuSel <= w_menuNext;
               end
               if (r_cool == '0) begin
                  r_state <= BROWSE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cool <= r_cool - 1'b1;
               end
            end
            default: begin
               r_state <= BROWSE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign w_lfsrNext = lfsrStep(r_lfsr);

   // random is taken from the next LFSR value so it always mirrors the register's low bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lfsr   <= LFSR_SEED;
         r_random <= LFSR_SEED[2:0];
      end else begin
         r_lfsr   <= w_lfsrNext;
         r_random <= w_lfsrNext[2:0];
      end
   end

   assign bus.actions  = r_actions;
   assign bus.random   = r_random;
   assign bus.menu_sel = r_menuSel;
   assign bus.busy     = r_busy;

endmodule

// File: tb/tb_care_input.sv
// Self-checking bench for care_input: table-driven press vectors plus hand-written
// sequences for latency, cooldown and mid-cooldown reset; pulses are scored from a queue.
module tb_care_input;

   localparam int DEB  = 4;
   localparam int COOL = 10;

   typedef struct {
      bit         doNext;
      bit         doSel;
      int         hold;
      logic [2:0] expMenu;
      logic [7:0] expAct;
      string      name;
   } vec_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] expQ[$];
   vec_t vecs[12];

   always #5 clk = ~clk;

   care_input_if bus();

   care_input #(
      .DEBOUNCE_CYCLES (DEB),
      .COOLDOWN_CYCLES (COOL),
      .NUM_ACTIONS     (6),
      .LFSR_SEED       (16'hACE1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [15:0] tbLfsr(input logic [15:0] v);
      logic [15:0] n;
      n = {1'b0, v[15:1]};
      if (v[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic nextLvl, input logic selLvl);
      bus.btn_next   = nextLvl;
      bus.btn_select = selLvl;
      @(posedge clk);
      #1;
   endtask

   // Every nonzero action cycle must match the oldest expected pulse.
   always @(negedge clk) begin
      if (!reset && bus.actions !== 8'h00) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedPulse actual=%0h expected=none", bus.actions);
         end else begin
            checkOutput("actionPulse", {8'h00, bus.actions}, {8'h00, expQ.pop_front()});
         end
      end
   end

   initial begin
      logic [15:0] model;
      int first;
      int busyCnt;
      int pulses;

      vecs[0]  = '{1'b1, 1'b0, 8, 3'd1, 8'h00, "next1"};
      vecs[1]  = '{1'b1, 1'b0, 8, 3'd2, 8'h00, "next2"};
      vecs[2]  = '{1'b1, 1'b0, 8, 3'd3, 8'h00, "next3"};
      vecs[3]  = '{1'b1, 1'b0, 8, 3'd4, 8'h00, "next4"};
      vecs[4]  = '{1'b1, 1'b0, 8, 3'd5, 8'h00, "next5"};
      vecs[5]  = '{1'b0, 1'b1, 8, 3'd5, 8'h20, "select5"};
      vecs[6]  = '{1'b1, 1'b0, 8, 3'd0, 8'h00, "nextWrap"};
      vecs[7]  = '{1'b0, 1'b1, 3, 3'd0, 8'h00, "glitch3"};
      vecs[8]  = '{1'b1, 1'b0, 8, 3'd1, 8'h00, "next1b"};
      vecs[9]  = '{1'b1, 1'b0, 8, 3'd2, 8'h00, "next2b"};
      vecs[10] = '{1'b0, 1'b1, 4, 3'd2, 8'h04, "selectMinHold"};
      vecs[11] = '{1'b1, 1'b1, 8, 3'd2, 8'h04, "bothSameCycle"};

      bus.btn_next   = 1'b0;
      bus.btn_select = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("resetActions", {8'h00, bus.actions}, 16'h0000);
      checkOutput("resetMenu", {13'h0, bus.menu_sel}, 16'h0000);
      checkOutput("resetBusy", {15'h0, bus.busy}, 16'h0000);
      checkOutput("resetRandom", {13'h0, bus.random}, 16'h0001);
      reset = 1'b0;

      model = 16'hACE1;
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b0, 1'b0);
         model = tbLfsr(model);
         checkOutput($sformatf("random%0d", k), {13'h0, bus.random}, {13'h0, model[2:0]});
      end
      checkOutput("idleActions", {8'h00, bus.actions}, 16'h0000);
      checkOutput("idleMenu", {13'h0, bus.menu_sel}, 16'h0000);
      checkOutput("idleBusy", {15'h0, bus.busy}, 16'h0000);

      expQ.push_back(8'h01);
      first = 0;
      busyCnt = 0;
      for (int k = 1; k <= 40; k++) begin
         applyStimulus(1'b0, k <= 20);
         if (bus.actions !== 8'h00 && first == 0) first = k;
         if (bus.busy === 1'b1) busyCnt++;
      end
      checkOutput("selectLatency", 16'(first), 16'd8);
      checkOutput("busyLength", 16'(busyCnt), 16'd11);
      checkOutput("menuAfterSelect", {13'h0, bus.menu_sel}, 16'h0000);

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].expAct != 8'h00) expQ.push_back(vecs[i].expAct);
         for (int k = 0; k < vecs[i].hold; k++) applyStimulus(vecs[i].doNext, vecs[i].doSel);
         for (int k = 0; k < 30; k++) applyStimulus(1'b0, 1'b0);
         checkOutput({vecs[i].name, "Menu"}, {13'h0, bus.menu_sel}, {13'h0, vecs[i].expMenu});
         checkOutput({vecs[i].name, "Busy"}, {15'h0, bus.busy}, 16'h0000);
         checkOutput({vecs[i].name, "Pending"}, 16'(expQ.size()), 16'h0000);
      end

      expQ.push_back(8'h04);
      pulses = 0;
      busyCnt = 0;
      for (int k = 1; k <= 50; k++) begin
         applyStimulus(k >= 9 && k <= 16, k <= 4 || (k >= 9 && k <= 16));
         if (bus.actions !== 8'h00) pulses++;
         if (bus.busy === 1'b1) busyCnt++;
      end
      checkOutput("cooldownPulses", 16'(pulses), 16'd1);
      checkOutput("cooldownBusy", 16'(busyCnt), 16'd11);
      checkOutput("cooldownNextMenu", {13'h0, bus.menu_sel}, 16'h0003);

      expQ.push_back(8'h08);
      for (int k = 1; k <= 12; k++) applyStimulus(1'b0, k <= 8);
      checkOutput("busyBeforeReset", {15'h0, bus.busy}, 16'h0001);
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0);
      reset = 1'b0;
      checkOutput("midResetBusy", {15'h0, bus.busy}, 16'h0000);
      checkOutput("midResetMenu", {13'h0, bus.menu_sel}, 16'h0000);
      checkOutput("midResetActions", {8'h00, bus.actions}, 16'h0000);
      checkOutput("midResetRandom", {13'h0, bus.random}, 16'h0001);
      applyStimulus(1'b0, 1'b0);
      checkOutput("postResetRandom", {13'h0, bus.random}, 16'h0000);

      expQ.push_back(8'h01);
      first = 0;
      for (int k = 1; k <= 40; k++) begin
         applyStimulus(1'b0, k <= 8);
         if (bus.actions !== 8'h00 && first == 0) first = k;
      end
      checkOutput("browseAfterReset", 16'(first), 16'd8);
      checkOutput("queueEmpty", 16'(expQ.size()), 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/care_input.md
Name: care_input

Overview:
- Front-end stage that feeds the stat-keeping block.
- Converts two raw push-buttons (next, select) into debounced menu navigation.
- A confirmed select produces a one-cycle action pulse on the 8-bit action bus; each bit lowers one stat.
- Also supplies the 3-bit pseudo-random selector that picks which stat rises on each decay tick.

Parameters:
- DEBOUNCE_CYCLES, 270000, consecutive stable cycles required before a button level is accepted (10 ms at 27 MHz); legal range 1 or more.
- COOLDOWN_CYCLES, 13500000, cycles after an action during which select is ignored (0.5 s); legal range 1 or more.
- NUM_ACTIONS, 6, number of selectable actions (hunger, happiness, health, hygiene, energy, social); legal range 1 to 8.
- LFSR_SEED, 16'hACE1, reset value of the random LFSR; must be nonzero.

Ports:
- clk  in  1  27 MHz system clock
- reset  in  1  synchronous, active-high reset
- btn_next  in  1  raw asynchronous button, high = pressed
- btn_select  in  1  raw asynchronous button, high = pressed
- actions  out  8  one-hot, one-cycle action pulse; bit i = action i; bits at or above NUM_ACTIONS are always 0
- random  out  3  pseudo-random selector for the stat block
- menu_sel  out  3  currently highlighted action index, 0 to NUM_ACTIONS-1
- busy  out  1  high while in FIRE or COOLDOWN

Behaviour:
- Reset (synchronous, active-high): clears everything on the next clk edge, including mid-debounce and mid-cooldown.
  - actions=0, menu_sel=0, busy=0, FSM=BROWSE, LFSR=LFSR_SEED, random=LFSR_SEED[2:0].
  - Synchronisers, stable levels, debounce counters and cooldown counter all go to 0.
- Synchroniser: each button passes through a 2-FF synchroniser.
- Debounce (one instance per button):
  - Counter increments while the synced level differs from the stable level; it clears whenever they agree.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable level toggles on the next edge and the counter clears.
- Edge detect: a press event is a registered rising edge of the stable level, one cycle wide. Release events are ignored.
- Latency: button held high produces the press event DEBOUNCE_CYCLES+3 cycles after the first clk edge that samples it high. The action pulse follows 1 cycle later.
- FSM states:
  - BROWSE:
    - next event: menu_sel increments, wrapping NUM_ACTIONS-1 to 0.
    - select event: go to FIRE.
    - Both events in the same cycle: select wins, menu_sel is unchanged, next is discarded.
  - FIRE (exactly 1 cycle): actions = 1 << menu_sel, busy=1, load cooldown counter with COOLDOWN_CYCLES-1, go to COOLDOWN.
  - COOLDOWN:
    - busy=1; counter decrements; at 0, go to BROWSE on the next edge.
    - next events still navigate (menu_sel updates).
    - select events are dropped, not queued.
- actions is registered and is 0 in every cycle other than FIRE.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400), shifts right every cycle.
  - random = lfsr[2:0], registered.
  - Values 6 and 7 are legal and mean "no stat this tick" to the consumer.
  - The LFSR never reaches all-zero when seeded nonzero.
- No output depends combinationally on a raw input.

Decomposition:
- Shared package holds:
  - Action index constants: ACT_FEED=0, ACT_PLAY=1, ACT_HEAL=2, ACT_CLEAN=3, ACT_SLEEP=4, ACT_CHAT=5.
  - NUM_ACTIONS_DEFAULT=6.
  - LFSR_MASK=16'hB400.
  - FSM state encoding: BROWSE, FIRE, COOLDOWN.
- The stat block reuses these action constants for its input bit assignment.
- One sub-module, button_debounce (synchroniser, stability counter, rising-edge pulse), instantiated twice.
- LFSR and FSM stay inline.

Test Plan (DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=10):
- Reset, then idle 20 cycles -> actions=0, menu_sel=0, busy=0; random follows the LFSR sequence from 16'hACE1 (first value 3'b001, then lfsr=16'hE270 gives 3'b000).
- btn_select held high 20 cycles from BROWSE, menu_sel=0 -> actions=8'h01 for exactly one cycle, DEBOUNCE_CYCLES+4=8 cycles after the first sampled high; busy high for 11 cycles.
- btn_select glitch high for 3 cycles, then low -> no press event, actions stays 0.
- Six clean next presses -> menu_sel goes 1,2,3,4,5,0. With menu_sel=5, a select gives actions=8'h20.
- Second select press during COOLDOWN -> no second pulse. A next press during COOLDOWN still advances menu_sel.
- Next and select stable edges in the same cycle with menu_sel=2 -> actions=8'h04, menu_sel stays 2.
- Reset asserted mid-COOLDOWN -> the following cycle busy=0, menu_sel=0, FSM=BROWSE, lfsr=16'hACE1.
